// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder and its stdout FIFO.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  localparam logic [31:0] STDOUT_ADDR_DEFAULT = 32'hFFFF_0000;

  // Wide enough for WAIT_CYCLES up to 15.
  localparam int WAIT_CNT_W = 4;

endpackage

// File: rtl/stdout_fifo.sv
// Synchronous FIFO feeding the console sink; a push while full is accepted when a pop
// happens in the same cycle.
module stdout_fifo #(
  parameter  int DEPTH = 8,
  parameter  int WIDTH = 8,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(do_push);
    rd_ptr_d = rd_ptr_q + PW'(do_pop);
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately left out of reset; the count alone decides validity.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM with wait states plus a memory-mapped stdout FIFO.
// Optional byte-lane store enables are compiled in with DMEM_BYTE_LANE_EN.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_CYCLES = 1,
  parameter logic [31:0] STDOUT_ADDR = STDOUT_ADDR_DEFAULT,
  parameter int          FIFO_DEPTH  = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
`ifdef DMEM_BYTE_LANE_EN
  input  logic [3:0]  req_be,
`endif
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        cout_valid,
  input  logic        cout_ready,
  output logic [7:0]  cout_data
);

  localparam int                    AW        = $clog2(DEPTH_WORDS);
  localparam int                    FCW       = $clog2(FIFO_DEPTH) + 1;
  localparam logic [31:0]           RAM_BYTES = 32'(4 * DEPTH_WORDS);
  localparam logic [WAIT_CNT_W-1:0] CNT_LOAD  =
    (WAIT_CYCLES == 0) ? '0 : WAIT_CNT_W'(WAIT_CYCLES - 1);

  state_e                state_q, state_d;
  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
  logic                  write_q, write_d;
  logic [31:0]           addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [3:0]            be_q, be_d;
  logic [31:0]           rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;

  logic [31:0] mem_q [DEPTH_WORDS];

  logic [3:0]     req_be_w;
  logic           cur_write, cur_is_stdout, cur_err, stdout_push_req;
  logic [31:0]    cur_addr, cur_wdata;
  logic [3:0]     cur_be;
  logic [AW-1:0]  cur_idx;
  logic           commit, can_commit, mem_we;
  logic           fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [FCW-1:0] fifo_count;

`ifdef DMEM_BYTE_LANE_EN
  assign req_be_w = req_be;
`else
  assign req_be_w = 4'hF;
`endif

  // With WAIT_CYCLES=0 the access commits in the accept cycle, straight from the request.
  assign cur_write = (state_q == IDLE) ? req_write : write_q;
  assign cur_addr  = (state_q == IDLE) ? req_addr  : addr_q;
  assign cur_wdata = (state_q == IDLE) ? req_wdata : wdata_q;
  assign cur_be    = (state_q == IDLE) ? req_be_w  : be_q;

  assign cur_idx         = cur_addr[AW+1:2];
  assign cur_is_stdout   = (cur_addr == STDOUT_ADDR);
  assign cur_err         = (cur_addr[1:0] != 2'b00) || (!cur_is_stdout && (cur_addr >= RAM_BYTES));
  assign stdout_push_req = cur_write && cur_is_stdout && !cur_err && cur_be[0];
  assign can_commit      = !stdout_push_req || !fifo_full || fifo_pop;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    write_d     = write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;
    commit      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          be_d    = req_be_w;
          if (WAIT_CYCLES == 0 && can_commit) begin
            commit  = 1'b1;
            state_d = RESP;
          end else begin
            cnt_d   = CNT_LOAD;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (can_commit) begin
          commit  = 1'b1;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (commit) begin
      rsp_err_d = cur_err;
      if (!cur_err && !cur_write)
        rsp_rdata_d = cur_is_stdout ? {24'b0, 8'(fifo_count)} : mem_q[cur_idx];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Side effects are gated by reset so an interrupted access leaves no trace.
  assign mem_we    = commit && cur_write && !cur_is_stdout && !cur_err && !reset;
  assign fifo_push = commit && stdout_push_req && !reset;
  assign fifo_pop  = cout_valid && cout_ready;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++)
        if (cur_be[i]) mem_q[cur_idx][8*i +: 8] <= cur_wdata[8*i +: 8];
    end
  end

  stdout_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_stdout_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (cur_wdata[7:0]),
    .full      (fifo_full),
    .pop       (fifo_pop),
    .pop_data  (cout_data),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign req_ready  = (state_q == IDLE);
  assign rsp_valid  = (state_q == RESP);
  assign rsp_rdata  = rsp_rdata_q;
  assign rsp_err    = rsp_err_q;
  assign cout_valid = !fifo_empty;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: expected responses and console bytes are queued
// as stimulus is driven and compared as the DUT produces them.
module tb_dmem_responder;

  localparam int          DEPTH_WORDS = 1024;
  localparam int          WAIT_CYCLES = 1;
  localparam int          FIFO_DEPTH  = 8;
  localparam logic [31:0] STDOUT_ADDR = 32'hFFFF_0000;
  localparam int          LAT         = WAIT_CYCLES + 1;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        cout_valid, cout_ready;
  logic [7:0]  cout_data;

  int checks = 0;
  int errors = 0;

  rsp_t       exp_q[$];
  logic [7:0] exp_cout[$];
  logic [7:0] got_cout[$];

  always #5 clk = ~clk;

  dmem_responder #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .WAIT_CYCLES (WAIT_CYCLES),
    .STDOUT_ADDR (STDOUT_ADDR),
    .FIFO_DEPTH  (FIFO_DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
`ifdef DMEM_BYTE_LANE_EN
    .req_be     (req_be),
`endif
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .cout_valid (cout_valid),
    .cout_ready (cout_ready),
    .cout_data  (cout_data)
  );

  // Record every byte the console sink takes, sampled mid-cycle before the popping edge.
  always @(negedge clk) begin
    if (!reset && cout_valid && cout_ready) got_cout.push_back(cout_data);
  end

  // Issue one access and wait for its response; lat = -1 means it never came.
  task automatic access(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input int budget,
                        output logic [31:0] rdata, output logic err, output int lat);
    int n;
    bit done;
    lat   = -1;
    rdata = '0;
    err   = 1'b0;
    done  = 1'b0;
    n     = 0;
    while (!req_ready && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    for (int k = 1; k <= budget && !done; k++) begin
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      if (rsp_valid) begin
        lat   = k;
        rdata = rsp_rdata;
        err   = rsp_err;
        done  = 1'b1;
      end
    end
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    req_be     = 4'hF;
    cout_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b exp 1", req_ready); end
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
    checks++;
    if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rsp_rdata got %h exp 0", rsp_rdata); end
    checks++;
    if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err got %b exp 0", rsp_err); end
    checks++;
    if (cout_valid !== 1'b0) begin errors++; $display("FAIL reset_cout_valid got %b exp 0", cout_valid); end
  endtask

  task automatic test_load_store();
    logic [31:0] r; logic e; int lat; rsp_t x;
    exp_q.push_back('{rdata: 32'h0, err: 1'b0});
    access(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 50, r, e, lat);
    x = exp_q.pop_front();
    checks++;
    if ({r, e} !== {x.rdata, x.err}) begin errors++; $display("FAIL store_rsp got %h/%b exp %h/%b", r, e, x.rdata, x.err); end
    checks++;
    if (lat != LAT) begin errors++; $display("FAIL store_latency got %0d exp %0d", lat, LAT); end
    exp_q.push_back('{rdata: 32'hDEAD_BEEF, err: 1'b0});
    access(1'b0, 32'h10, 32'h0, 4'hF, 50, r, e, lat);
    x = exp_q.pop_front();
    checks++;
    if ({r, e} !== {x.rdata, x.err}) begin errors++; $display("FAIL load_rsp got %h/%b exp %h/%b", r, e, x.rdata, x.err); end
    checks++;
    if (lat != LAT) begin errors++; $display("FAIL load_latency got %0d exp %0d", lat, LAT); end
  endtask

  task automatic test_errors();
    logic [31:0] r; logic e; int lat; rsp_t x;
    logic [31:0] addrs [4];
    logic        wrs   [4];
    addrs = '{32'h12, 32'(4 * DEPTH_WORDS), 32'h10, STDOUT_ADDR};
    wrs   = '{1'b0, 1'b1, 1'b0, 1'b0};
    exp_q.push_back('{rdata: 32'h0,         err: 1'b1});
    exp_q.push_back('{rdata: 32'h0,         err: 1'b1});
    exp_q.push_back('{rdata: 32'hDEAD_BEEF, err: 1'b0});
    exp_q.push_back('{rdata: 32'h0,         err: 1'b0});
    for (int i = 0; i < 4; i++) begin
      access(wrs[i], addrs[i], 32'h5555_AAAA, 4'hF, 50, r, e, lat);
      x = exp_q.pop_front();
      checks++;
      if ({r, e} !== {x.rdata, x.err} || lat != LAT)
        begin errors++; $display("FAIL err_case%0d got %h/%b lat %0d exp %h/%b lat %0d", i, r, e, lat, x.rdata, x.err, LAT); end
    end
  endtask

  task automatic test_stdout_hi();
    logic [31:0] r; logic e; int lat;
    got_cout.delete();
    exp_cout.delete();
    cout_ready = 1'b1;
    exp_cout.push_back(8'h48);
    access(1'b1, STDOUT_ADDR, 32'hABCD_EF48, 4'hF, 50, r, e, lat);
    exp_cout.push_back(8'h69);
    access(1'b1, STDOUT_ADDR, 32'h1234_5669, 4'hF, 50, r, e, lat);
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (got_cout.size() != exp_cout.size())
      begin errors++; $display("FAIL hi_count got %0d exp %0d", got_cout.size(), exp_cout.size()); end
    while (got_cout.size() > 0 && exp_cout.size() > 0) begin
      logic [7:0] g, w;
      g = got_cout.pop_front();
      w = exp_cout.pop_front();
      checks++;
      if (g !== w) begin errors++; $display("FAIL hi_byte got %h exp %h", g, w); end
    end
  endtask

  task automatic test_fifo_full();
    logic [31:0] r; logic e; int lat; rsp_t x;
    got_cout.delete();
    exp_cout.delete();
    cout_ready = 1'b0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      exp_cout.push_back(8'(8'h30 + i));
      access(1'b1, STDOUT_ADDR, 32'(8'h30 + i), 4'hF, 50, r, e, lat);
      checks++;
      if (lat != LAT) begin errors++; $display("FAIL fill_latency%0d got %0d exp %0d", i, lat, LAT); end
    end
    exp_cout.push_back(8'(8'h30 + FIFO_DEPTH));
    fork
      access(1'b1, STDOUT_ADDR, 32'(8'h30 + FIFO_DEPTH), 4'hF, 100, r, e, lat);
      begin
        repeat (20) @(posedge clk);
        #2 cout_ready = 1'b1;
        @(posedge clk);
        #2 cout_ready = 1'b0;
      end
    join
    checks++;
    if (lat < 15 || lat > 30) begin errors++; $display("FAIL stall_latency got %0d exp 15..30", lat); end
    checks++;
    if (got_cout.size() != 1) begin errors++; $display("FAIL stall_pops got %0d exp 1", got_cout.size()); end
    exp_q.push_back('{rdata: 32'(FIFO_DEPTH), err: 1'b0});
    access(1'b0, STDOUT_ADDR, 32'h0, 4'hF, 50, r, e, lat);
    x = exp_q.pop_front();
    checks++;
    if ({r, e} !== {x.rdata, x.err}) begin errors++; $display("FAIL occupancy got %h/%b exp %h/%b", r, e, x.rdata, x.err); end
    cout_ready = 1'b1;
    repeat (FIFO_DEPTH + 4) @(posedge clk);
    #1;
    cout_ready = 1'b0;
    checks++;
    if (got_cout.size() != exp_cout.size())
      begin errors++; $display("FAIL drain_count got %0d exp %0d", got_cout.size(), exp_cout.size()); end
    while (got_cout.size() > 0 && exp_cout.size() > 0) begin
      logic [7:0] g, w;
      g = got_cout.pop_front();
      w = exp_cout.pop_front();
      checks++;
      if (g !== w) begin errors++; $display("FAIL drain_byte got %h exp %h", g, w); end
    end
  endtask

  task automatic test_reset_mid_access();
    logic [31:0] r; logic e; int lat; rsp_t x;
    bit seen;
    access(1'b1, 32'h20, 32'hAAAA_5555, 4'hF, 50, r, e, lat);
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 32'h20;
    req_wdata = 32'h0000_1234;
    req_be    = 4'hF;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    reset     = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    seen  = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (rsp_valid) seen = 1'b1;
      @(posedge clk);
      #1;
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL reset_drop_rsp got %b exp 0", seen); end
    exp_q.push_back('{rdata: 32'hAAAA_5555, err: 1'b0});
    access(1'b0, 32'h20, 32'h0, 4'hF, 50, r, e, lat);
    x = exp_q.pop_front();
    checks++;
    if ({r, e} !== {x.rdata, x.err}) begin errors++; $display("FAIL reset_no_write got %h/%b exp %h/%b", r, e, x.rdata, x.err); end
  endtask

`ifdef DMEM_BYTE_LANE_EN
  task automatic test_byte_lanes();
    logic [31:0] r; logic e; int lat; rsp_t x;
    access(1'b1, 32'h40, 32'hFFFF_FFFF, 4'hF, 50, r, e, lat);
    access(1'b1, 32'h40, 32'h0000_0000, 4'b0101, 50, r, e, lat);
    exp_q.push_back('{rdata: 32'hFF00_FF00, err: 1'b0});
    access(1'b0, 32'h40, 32'h0, 4'hF, 50, r, e, lat);
    x = exp_q.pop_front();
    checks++;
    if ({r, e} !== {x.rdata, x.err}) begin errors++; $display("FAIL be_0101 got %h/%b exp %h/%b", r, e, x.rdata, x.err); end
    access(1'b1, 32'h40, 32'h1234_5678, 4'b0000, 50, r, e, lat);
    exp_q.push_back('{rdata: 32'hFF00_FF00, err: 1'b0});
    access(1'b0, 32'h40, 32'h0, 4'hF, 50, r, e, lat);
    x = exp_q.pop_front();
    checks++;
    if ({r, e} !== {x.rdata, x.err}) begin errors++; $display("FAIL be_noop got %h/%b exp %h/%b", r, e, x.rdata, x.err); end
  endtask
`endif

  initial begin
    test_reset();
    test_load_store();
    test_errors();
    test_stdout_hi();
    test_fifo_full();
    test_reset_mid_access();
`ifdef DMEM_BYTE_LANE_EN
    test_byte_lanes();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

endmodule
